// File: rtl/data_ram_responder_pkg.sv
// Shared types and constants for the CPU data-memory responder and its MMIO window.
package data_ram_responder_pkg;

  typedef logic [15:0] word_t;

  // MMIO register offsets relative to MMIO_BASE
  localparam word_t OFF_OUTDATA = 16'd0;
  localparam word_t OFF_STATUS  = 16'd1;
  localparam word_t OFF_TIMER   = 16'd2;
  localparam word_t OFF_INPORT  = 16'd3;

  // STATUS register bit positions; the occupancy count starts at ST_COUNT_LSB
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO of 16-bit words with occupancy count; head word reads as 0 when empty.
module sync_fifo
  import data_ram_responder_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  word_t         wdata_i,
  input  logic          pop_i,
  output word_t         rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  word_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; empty/count gate its visibility, and a reset would block RAM inference.
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/data_ram_responder.sv
// CPU data-memory responder: word RAM plus MMIO output FIFO, status, timer and input port.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int    ADDR_W     = 10,
  parameter word_t MMIO_BASE  = 16'hFF00,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  word_t data_ram_addr,
  input  logic  data_ram_wen,
  input  word_t data_ram_wdata,
  output word_t data_ram_rdata,
  output logic  out_valid,
  output word_t out_data,
  input  logic  out_ready,
  input  word_t in_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  word_t         ram_q [2**ADDR_W];
  word_t         timer_q, timer_d;
  word_t         inport_q;
  logic          ovf_q, ovf_d;
  logic          is_mmio, mmio_wr;
  word_t         mmio_off;
  word_t         status;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          ovf_set, ovf_clr;

  assign is_mmio  = (data_ram_addr >= MMIO_BASE);
  assign mmio_off = data_ram_addr - MMIO_BASE;
  assign mmio_wr  = data_ram_wen && is_mmio;

  assign fifo_push = mmio_wr && (mmio_off == OFF_OUTDATA);
  assign fifo_pop  = out_valid && out_ready;
  assign out_valid = !fifo_empty;

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (data_ram_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A push only overflows when the FIFO is full and nothing leaves in the same cycle.
  assign ovf_set = fifo_push && fifo_full && !fifo_pop;
  assign ovf_clr = mmio_wr && (mmio_off == OFF_STATUS) && data_ram_wdata[ST_OVF];

  // Next-state for overflow sticky (set has priority) and the free-running, loadable timer.
  always_comb begin
    ovf_d   = ovf_q;
    timer_d = timer_q + 16'd1;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    if (mmio_wr && (mmio_off == OFF_TIMER)) timer_d = data_ram_wdata;
  end

  // MMIO state registers with synchronous reset; the input port is sampled every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q    <= 1'b0;
      timer_q  <= '0;
      inport_q <= '0;
    end else begin
      ovf_q    <= ovf_d;
      timer_q  <= timer_d;
      inport_q <= in_data;
    end
  end

  // RAM write port; upper address bits alias onto the index.
  always_ff @(posedge clk) begin
    if (data_ram_wen && !is_mmio) ram_q[data_ram_addr[ADDR_W-1:0]] <= data_ram_wdata;
  end

  // Combinational read mux: RAM word (pre-write value) or MMIO register.
  always_comb begin
    status                          = '0;
    status[ST_FULL]                 = fifo_full;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_OVF]                  = ovf_q;
    status[ST_COUNT_LSB +: CW]      = fifo_count;
    data_ram_rdata                  = '0;
    if (!is_mmio) begin
      data_ram_rdata = ram_q[data_ram_addr[ADDR_W-1:0]];
    end else begin
      case (mmio_off)
        OFF_STATUS: data_ram_rdata = status;
        OFF_TIMER:  data_ram_rdata = timer_q;
        OFF_INPORT: data_ram_rdata = inport_q;
        default:    data_ram_rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder end of the CPU data-memory interface: receives address, write-enable and write data from the A/D register block and returns read data in the same cycle.
- Holds the data RAM array plus a small memory-mapped I/O window:
  - output FIFO with valid/ready drain port
  - status register
  - free-running timer
  - registered input port
- Sits between the CPU core and the top-level pins/peripherals.

Parameters:
ADDR_W, 10, RAM index width; RAM holds 2**ADDR_W 16-bit words
MMIO_BASE, 16'hFF00, first MMIO address; addresses >= MMIO_BASE are MMIO, all others are RAM
FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
data_ram_addr  input  16  word address from CPU (A register)
data_ram_wen  input  1  write strobe; write is committed at the next posedge clk
data_ram_wdata  input  16  write data
data_ram_rdata  output  16  read data; combinational from data_ram_addr
out_valid  output  1  output FIFO holds at least one word
out_data  output  16  FIFO head word
out_ready  input  1  consumer accepts the head word
in_data  input  16  external input port

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On reset:
  - FIFO empty, so out_valid = 0 and out_data = 0.
  - Overflow sticky = 0, timer = 0, input register = 0.
  - RAM contents are not reset.
- RAM region (addr < MMIO_BASE):
  - Index is addr[ADDR_W-1:0]; higher address bits alias.
  - Read is combinational, with zero latency.
  - Write stores wdata at the posedge while wen = 1.
  - Read during a write to the same address returns the old word; the new word is visible the cycle after.
- MMIO map (offset = addr - MMIO_BASE):
  - +0 OUTDATA. Write pushes wdata into the FIFO. If the FIFO is full and no pop occurs that cycle, the write is dropped and overflow is set. Read returns 0.
  - +1 STATUS. Read returns:
    - bit0 = full
    - bit1 = empty
    - bit2 = overflow
    - bits[2+clog2(FIFO_DEPTH)+1:3] = occupancy count
    - all other bits 0
    A write with wdata[2] = 1 clears overflow; the write has no other effect.
  - +2 TIMER. Counter increments by 1 every cycle and wraps from 16'hFFFF to 0. A write loads wdata, so a read on the next cycle returns wdata and the cycle after returns wdata+1. Read returns the current value.
  - +3 INPORT. in_data is registered once every cycle; read returns the registered value, so latency is one cycle from the pin. Write is ignored.
  - Other MMIO offsets: read returns 0, write is ignored.
- Output FIFO:
  - out_data is the head word, and is 0 when empty.
  - A pop occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_data is held stable.
  - Push and pop in the same cycle: count is unchanged. This applies when full, and the push is then not an overflow.
  - Push when empty: out_valid rises on the next cycle.
  - out_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow set and clear in the same cycle: set wins (sticky stays 1).
- A reset asserted mid-operation discards FIFO contents at that posedge, regardless of wen or out_ready.

Decomposition:
- Shared package:
  - MMIO offset constants: OFF_OUTDATA=0, OFF_STATUS=1, OFF_TIMER=2, OFF_INPORT=3
  - STATUS bit-position constants
  - 16-bit word typedef
- One natural sub-module: sync_fifo (parameter DEPTH and width 16; push/full, pop/empty, count). It is instantiated once for the output FIFO.
- Address decode, RAM, timer and input register stay in the top module.

Test Plan:
- RAM write/read: write 16'h1234 to 16'h0005, then read 16'h0005 the next cycle -> 16'h1234. Read in the same cycle as the write -> previous content. With ADDR_W=10, read 16'h0405 -> 16'h1234 (alias).
- FIFO fill and overflow, out_ready=0: push 1,2,3,4, STATUS -> 16'h0021 (full, count=4). Push 5 -> STATUS -> 16'h0025 (overflow set). Assert out_ready -> out_data sequence 1,2,3,4, then out_valid=0 and STATUS -> 16'h0006 (empty, overflow set). Write 16'h0004 to STATUS -> 16'h0002.
- Simultaneous push/pop when full: FIFO holds 1..4, out_ready=1, push 9 in the same cycle -> count stays 4, overflow stays 0, drain order 2,3,4,9.
- Timer load: write 16'hFFFE to TIMER -> reads return FFFE, FFFF, 0000 on the next three cycles.
- Input port latency: in_data changes 0->16'hBEEF at cycle N -> INPORT read returns 0 at N and 16'hBEEF at N+1. An unmapped offset +7 reads 0.
- Reset mid-drain: FIFO holds 3 words, assert rst_n=0 for one cycle -> out_valid=0 and out_data=0 afterwards, STATUS -> 16'h0002, TIMER -> 0.
